// File: rtl/vga_pkg.sv
// Shared geometry constants and the plot request record used by the VGA plot path.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 3;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
  } plot_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head entry is visible on rdata while not empty.
module sync_fifo #(
  parameter type data_t = logic [17:0],
  parameter int  DEPTH  = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  push,
  input  logic  pop,
  input  data_t wdata,
  output data_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  data_t       mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // flush wins over both ports so a flushed cycle never moves data
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr_reg[AW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}});

endmodule

// File: rtl/plot_clip_fifo.sv
// Drops off-screen plot requests, buffers the rest and replays them as one-cycle VGA plot strobes.
module plot_clip_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        out_stall,
  output logic [7:0]  VGA_X,
  output logic [6:0]  VGA_Y,
  output logic [2:0]  VGA_COLOUR,
  output logic        VGA_PLOT,
  output logic        empty,
  output logic        full,
  output logic [15:0] clip_count
);

  localparam logic [31:0] X_LIM = 32'(SCREEN_W);
  localparam logic [31:0] Y_LIM = 32'(SCREEN_H);

  plot_t       wr_entry;
  plot_t       head_entry;
  logic        on_screen;
  logic        accept;
  logic        fifo_push;
  logic        fifo_pop;
  plot_t       out_reg;
  logic        plot_reg;
  logic [15:0] clip_count_reg;

  assign on_screen = (32'(in_x) < X_LIM) && (32'(in_y) < Y_LIM);
  assign in_ready  = !full;
  assign accept    = in_valid && in_ready && !flush;
  assign fifo_push = accept && on_screen;
  assign fifo_pop  = !empty && !out_stall && !flush;

  assign wr_entry.x      = in_x;
  assign wr_entry.y      = in_y;
  assign wr_entry.colour = in_colour;

  sync_fifo #(
    .data_t (plot_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (rst_n),
    .flush (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wr_entry),
    .rdata (head_entry),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      out_reg  <= '0;
      plot_reg <= 1'b0;
    end else begin
      plot_reg <= fifo_pop;
      if (fifo_pop) out_reg <= head_entry;
    end
  end

  // the counter sticks at all-ones rather than wrapping
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      clip_count_reg <= '0;
    end else if (accept && !on_screen && (clip_count_reg != 16'hFFFF)) begin
      clip_count_reg <= clip_count_reg + 16'd1;
    end
  end

  assign VGA_X      = out_reg.x;
  assign VGA_Y      = out_reg.y;
  assign VGA_COLOUR = out_reg.colour;
  assign VGA_PLOT   = plot_reg;
  assign clip_count = clip_count_reg;

endmodule

// File: doc/plot_clip_fifo.md
Name: plot_clip_fifo

Overview:
Downstream stage between any pixel generator (screen fill, line or circle drawer) and the VGA adapter plot port. It accepts plot requests on a valid/ready handshake and drops any request whose coordinates are off-screen. Surviving requests are buffered in a small FIFO and replayed as single-cycle VGA_X/VGA_Y/VGA_COLOUR/VGA_PLOT pulses, so that generators are decoupled from adapter stalls.

Parameters:
DEPTH, 8, FIFO entries; must be a power of two and at least 2.
SCREEN_W, 160, visible width; an x coordinate is valid when x < SCREEN_W.
SCREEN_H, 120, visible height; a y coordinate is valid when y < SCREEN_H.

Ports:
CLOCK_50  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset (driven from KEY[3] at top level).
flush  input  1  synchronous; empties the FIFO.
in_valid  input  1  a plot request is presented.
in_ready  output  1  the block can accept a request; equals !full.
in_x  input  8  request x coordinate.
in_y  input  7  request y coordinate.
in_colour  input  3  request colour.
out_stall  input  1  the adapter cannot take a pixel this cycle.
VGA_X  output  8  registered x coordinate of the emitted pixel.
VGA_Y  output  7  registered y coordinate of the emitted pixel.
VGA_COLOUR  output  3  registered colour of the emitted pixel.
VGA_PLOT  output  1  registered one-cycle plot strobe.
empty  output  1  FIFO holds 0 entries.
full  output  1  FIFO holds DEPTH entries.
clip_count  output  16  number of dropped off-screen requests; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release): VGA_X = 0, VGA_Y = 0, VGA_COLOUR = 0, VGA_PLOT = 0, clip_count = 0, FIFO empty (empty = 1, full = 0, in_ready = 1).
- Accept: a transfer occurs on an edge where in_valid && in_ready.
  - If in_x < SCREEN_W and in_y < SCREEN_H, the request {x, y, colour} is written at the tail.
  - Otherwise the request is consumed but not stored, and clip_count increments (held once at 16'hFFFF).
- in_ready depends only on full. When the FIFO is full, a push is refused even if a pop happens on the same edge.
- Emit:
  - On an edge where the FIFO is non-empty and out_stall = 0, the head entry is popped into VGA_X/VGA_Y/VGA_COLOUR and VGA_PLOT is set to 1 for that cycle.
  - On every other edge VGA_PLOT = 0 and VGA_X/VGA_Y/VGA_COLOUR hold their last emitted values.
- Latency: a request accepted at edge N can be popped at edge N+1 at the earliest. With no stall, VGA_PLOT is high in the cycle after edge N+1. Requests are not bypassed.
- Throughput: one pixel per cycle when there is no stall; back-to-back pops give consecutive VGA_PLOT = 1 cycles.
- Ordering: strict FIFO; output order equals accepted (non-clipped) order.
- Simultaneous push and pop with the FIFO neither empty nor full: both occur and occupancy is unchanged.
- Push into an empty FIFO: the pop happens no earlier than the next edge.
- Pointers are log2(DEPTH)+1 bits wide with wrap-around. full is true when the pointers differ only in the MSB; empty is true when they are equal.
- flush = 1:
  - The pointers are cleared at that edge; no pop and no push take effect, VGA_PLOT = 0, and a push presented that cycle is not accepted.
  - in_ready is still driven as !full, but flush overrides the transfer.
  - clip_count is not cleared.
- Reset mid-operation discards all buffered entries immediately, and every output returns to its reset value asynchronously.
- Coordinate comparisons are unsigned. in_x = 8'd255 and in_y = 7'd127 are both clipped.

Decomposition:
- Package vga_pkg:
  - constants SCREEN_W = 160, SCREEN_H = 120, X_W = 8, Y_W = 7, C_W = 3;
  - typedef struct packed plot_t {x[7:0], y[6:0], colour[2:0]} (18 bits).
- Sub-module sync_fifo (parameterised width/depth, push/pop/flush, full/empty), instantiated with plot_t.
- plot_clip_fifo contains the clip comparators, the clip counter and the output registers.

Test Plan:
- Reset check: assert rst_n = 0, release -> VGA_X = 0, VGA_Y = 0, VGA_PLOT = 0, empty = 1, in_ready = 1, clip_count = 0.
- Single pixel: push (5, 7, 3) at edge N with out_stall = 0 -> VGA_PLOT = 1 with X = 5, Y = 7, C = 3 only in the cycle after edge N+1; next cycle VGA_PLOT = 0 and X/Y hold 5/7.
- Clipping: push (160, 0, 1), (0, 120, 1), (159, 119, 2) -> clip_count = 2; only (159, 119, 2) is emitted.
- Stall and full: out_stall = 1, push 9 valid pixels -> full = 1 and in_ready = 0 after the 8th; the 9th is held. Release stall -> 8 consecutive VGA_PLOT pulses in order, then the 9th.
- Full sweep: stream all 160x120 raster pixels with colour x % 8 and no stall -> 19200 VGA_PLOT pulses in raster order; the last is (159, 119, 7); then VGA_PLOT = 0 and X/Y hold 159/119.
- Flush and reset mid-stream: fill 5 entries, pulse flush -> empty = 1 and no further plots. Refill 3, pulse rst_n low mid-drain -> outputs return to 0 immediately and no stale entries are emitted after release.
